debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer; one instance filters CHANNELS raw push-button/switch inputs.
- Per channel: two-flop synchroniser, saturating stability counter, registered debounced level, and registered one-cycle rise/fall pulses.
- Sits between board pins and user logic. Downstream FSMs consume the pulses directly instead of building their own edge detectors.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- N, 11: counter width; the stable time required is 2^(N-1) clocks (N>=2).
- RESET_LEVEL, 0: value loaded into the synchronisers and DeBounce_Button_Out on reset (0 or 1).

Ports:
- DeBounce_CLOCK_50  in  1  single system clock; all logic is on its rising edge.
- DeBounce_Reset_InHigh  in  1  synchronous, active-high reset.
- DeBounce_Button_In  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- DeBounce_Button_Out  out  CHANNELS  debounced levels, registered.
- DeBounce_Rise_Pulse  out  CHANNELS  one-clock pulse when Out[i] goes 0->1.
- DeBounce_Fall_Pulse  out  CHANNELS  one-clock pulse when Out[i] goes 1->0.
- DeBounce_Any_Change  out  1  registered OR of all Rise and Fall bits, aligned with them.

Behaviour:
- Reset (sync, active-high), applied on the next edge:
  - DFF1[i] and DFF2[i] <= RESET_LEVEL; cnt[i] <= 0; Out[i] <= RESET_LEVEL.
  - All Rise, Fall and Any_Change <= 0.
  - Reset overrides all other activity, including mid-count.
- Synchroniser: DFF1[i] <= In[i]; DFF2[i] <= DFF1[i].
- Counter, per channel, N bits:
  - If DFF1[i] != DFF2[i]: cnt <= 0.
  - Else if cnt[N-1] == 0: cnt <= cnt + 1.
  - Else: hold. The counter saturates with the MSB set and never wraps.
- Output update:
  - When cnt[N-1] == 1: Out[i] <= DFF2[i]; otherwise Out[i] holds.
  - Out only takes a value that has been stable in DFF2 for at least 2^(N-1) clocks.
- Latency: In[i] changes and is first sampled into DFF1 at edge k, then stays stable. Out[i] changes at edge k + 2^(N-1) + 2.
- Pulses:
  - Rise[i] <= (next Out[i] == 1) & (Out[i] == 0); Fall is symmetric.
  - Each pulse is asserted in the same cycle Out[i] first shows its new value, for exactly 1 clock.
- Glitch/bounce: any DFF1/DFF2 mismatch restarts the count. A pulse shorter than 2^(N-1) clocks produces no Out change and no pulse.
- Saturated counter: an input toggle clears cnt at the mismatch edge. At that edge Out samples the old DFF2, so there is no spurious update.
- Simultaneous events: channels are fully independent. Multiple Rise/Fall bits may assert in the same cycle; Any_Change is a single 1-clock assertion.
- After reset with In == RESET_LEVEL: no pulses are generated.

Optional Feature:
- Macro: DEBOUNCE_CHANNEL_ENABLE_EN.
- Defined: adds input port DeBounce_Channel_Enable [CHANNELS], reset-independent.
  - While En[i] == 0: cnt[i] is forced to 0, Out[i] holds, and Rise/Fall[i] are forced to 0. The synchroniser still runs.
  - On re-enable, a full 2^(N-1)-clock stable period is needed before Out[i] can update.
- Undefined: the port is absent and all channels are always enabled.

Test Plan:
Settings for all scenarios: N=3 (stable time 4 clocks), CHANNELS=4, RESET_LEVEL=0.
1. Reset: hold reset 3 clocks with In=4'b1111 -> Out=0, Rise=Fall=0, Any_Change=0 throughout. Release with In=0 -> no pulses for 20 clocks.
2. Clean press: In[0] 0->1, sampled at edge k, held -> Out[0]=1 at edge k+6; Rise[0] and Any_Change high exactly at k+6 for 1 clock. Release -> Out[0]=0 and Fall[0] pulse 6 clocks after sampling.
3. Bounce: In[1] toggles every 2 clocks for 12 clocks, then held 1 -> Out[1]=1 exactly 6 clocks after the last sampled transition; exactly one Rise[1] pulse, zero Fall.
4. Glitch: In[2] high for 3 clocks only -> Out[2] stays 0; no Rise/Fall for 20 clocks.
5. Simultaneous: Out[3]=1 settled, then In[0] 0->1 and In[3] 1->0 on the same edge -> Rise[0] and Fall[3] in the same cycle; Any_Change high for 1 clock only.
6. Reset mid-count: In[0] 0->1; assert reset for 1 clock 3 clocks later; In held 1 -> Out[0] cleared to 0, then Out[0]=1 six clocks after the first post-reset sampling edge. With DEBOUNCE_CHANNEL_ENABLE_EN defined: En[0]=0 during the press -> no change; set En[0]=1 -> Out[0]=1 five clocks later.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per-channel 2-flop synchroniser, saturating
// stability counter, registered level and one-cycle rise/fall pulses.
// Optional per-channel enable port: define DEBOUNCE_CHANNEL_ENABLE_EN.
module debounce_multi #(
    parameter int   CHANNELS    = 4,
    parameter int   N           = 11,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                DeBounce_CLOCK_50,
    input  logic                DeBounce_Reset_InHigh,
    input  logic [CHANNELS-1:0] DeBounce_Button_In,
`ifdef DEBOUNCE_CHANNEL_ENABLE_EN
    input  logic [CHANNELS-1:0] DeBounce_Channel_Enable,
`endif
    output logic [CHANNELS-1:0] DeBounce_Button_Out,
    output logic [CHANNELS-1:0] DeBounce_Rise_Pulse,
    output logic [CHANNELS-1:0] DeBounce_Fall_Pulse,
    output logic                DeBounce_Any_Change
);

    logic [CHANNELS-1:0] chan_en;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;
    logic                any_change_q;

`ifdef DEBOUNCE_CHANNEL_ENABLE_EN
    assign chan_en = DeBounce_Channel_Enable;
`else
    assign chan_en = '1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic         dff1_q;
            logic         dff2_q;
            logic         out_q;
            logic         out_d;
            logic         rise_q;
            logic         fall_q;
            logic [N-1:0] cnt_q;
            logic [N-1:0] cnt_d;

            // Counter saturates at MSB set; a disabled channel keeps it cleared
            // so re-enabling demands a full stable period again.
            always_comb begin
                cnt_d = cnt_q;
                out_d = out_q;
                if (!chan_en[gi]) begin
                    cnt_d = '0;
                end else begin
                    if (dff1_q != dff2_q) begin
                        cnt_d = '0;
                    end else if (!cnt_q[N-1]) begin
                        cnt_d = cnt_q + N'(1);
                    end
                    if (cnt_q[N-1]) begin
                        out_d = dff2_q;
                    end
                end
            end

            assign rise_d[gi] = out_d & ~out_q;
            assign fall_d[gi] = ~out_d & out_q;

            always_ff @(posedge DeBounce_CLOCK_50) begin
                if (DeBounce_Reset_InHigh) begin
                    dff1_q <= RESET_LEVEL;
                    dff2_q <= RESET_LEVEL;
                    cnt_q  <= '0;
                    out_q  <= RESET_LEVEL;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    dff1_q <= DeBounce_Button_In[gi];
                    dff2_q <= dff1_q;
                    cnt_q  <= cnt_d;
                    out_q  <= out_d;
                    rise_q <= rise_d[gi];
                    fall_q <= fall_d[gi];
                end
            end

            assign DeBounce_Button_Out[gi] = out_q;
            assign DeBounce_Rise_Pulse[gi] = rise_q;
            assign DeBounce_Fall_Pulse[gi] = fall_q;
        end
    endgenerate

    // Computed from the same next-state terms as the pulses so it lines up with them.
    always_ff @(posedge DeBounce_CLOCK_50) begin
        if (DeBounce_Reset_InHigh) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= |(rise_d | fall_d);
        end
    end

    assign DeBounce_Any_Change = any_change_q;

endmodule
